// File: rtl/cpu_ctrl_pkg.sv
// Execution-control state encodings shared by the clock controller
// and the PDU display logic.
package cpu_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BREAK = 2'd3
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and
// one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int DB_CNT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT + 1) : 1;

    logic          s1;
    logic          s2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            pulse   <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= btn;
            s2      <= s1;
            level_d <= level;
            pulse   <= level & ~level_d;
            // any sample agreeing with the current level restarts the count
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CNT - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator with run, burst-step and PC breakpoint
// control on top of a divided tick.
module cpu_clk_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DIV     = 4,
    parameter int DB_CNT  = 16,
    parameter int PC_W    = 32,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    input  logic [BURST_W-1:0] burst_n,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_pc,
    input  logic [PC_W-1:0]    pc,
    output logic               tick,
    output logic               cpu_en,
    output logic               halted,
    output logic [STATE_W-1:0] state
);

    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DCW-1:0]     div_cnt;
    logic               run_s1;
    logic               run_s2;
    logic               step_pulse;
    logic               armed;
    logic               bp_hit;
    logic [BURST_W-1:0] remain;
    logic [BURST_W-1:0] burst_ld;
    state_t             st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == DCW'(DIV - 1));
            div_cnt <= (div_cnt == DCW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_s1 <= 1'b0;
            run_s2 <= 1'b0;
        end else begin
            run_s1 <= run;
            run_s2 <= run_s1;
        end
    end

    btn_debounce #(
        .DB_CNT(DB_CNT)
    ) u_step_db (
        .clk  (clk),
        .rst  (rst),
        .btn  (step),
        .pulse(step_pulse)
    );

    assign bp_hit   = bp_en && armed && (pc == bp_pc) && tick;
    assign cpu_en   = tick && (st == RUN || st == STEP) && !bp_hit;
    assign halted   = (st == BREAK);
    assign state    = st;
    assign burst_ld = (burst_n == '0) ? BURST_W'(1) : burst_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            remain <= '0;
            armed  <= 1'b1;
        end else begin
            // re-arm once the stopped instruction has been let through
            if (cpu_en) begin
                armed <= 1'b1;
            end
            unique case (st)
                IDLE: begin
                    if (run_s2) begin
                        st <= RUN;
                    end else if (step_pulse) begin
                        st     <= STEP;
                        remain <= burst_ld;
                    end
                end
                RUN: begin
                    if (!run_s2) begin
                        st <= IDLE;
                    end else if (bp_hit) begin
                        st    <= BREAK;
                        armed <= 1'b0;
                    end
                end
                STEP: begin
                    if (bp_hit) begin
                        st     <= BREAK;
                        armed  <= 1'b0;
                        remain <= '0;
                    end else if (cpu_en) begin
                        remain <= remain - 1'b1;
                        if (remain == BURST_W'(1)) begin
                            st <= IDLE;
                        end
                    end
                end
                BREAK: begin
                    if (step_pulse) begin
                        st     <= STEP;
                        remain <= burst_ld;
                    end else if (!run_s2) begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Randomised bench for cpu_clk_ctrl against an edge-history
// reference model of tick, run/step latency and breakpoint rules.
module tb_cpu_clk_ctrl;

    localparam int DIV     = 4;
    localparam int DB_CNT  = 4;
    localparam int PC_W    = 32;
    localparam int BURST_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               run;
    logic               step;
    logic [BURST_W-1:0] burst_n;
    logic               bp_en;
    logic [PC_W-1:0]    bp_pc;
    logic [PC_W-1:0]    pc;
    logic               tick;
    logic               cpu_en;
    logic               halted;
    logic [1:0]         state;

    int errors = 0;
    int checks = 0;
    int dut_en_cnt = 0;

    int e;
    bit m_tick;
    int m_st;
    int m_rem;
    bit m_arm;
    bit m_lvl;
    int last_chg;
    int last_rise;
    bit last_en;
    bit runq[$];
    bit stepq[$];

    cpu_clk_ctrl #(
        .DIV    (DIV),
        .DB_CNT (DB_CNT),
        .PC_W   (PC_W),
        .BURST_W(BURST_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .step   (step),
        .burst_n(burst_n),
        .bp_en  (bp_en),
        .bp_pc  (bp_pc),
        .pc     (pc),
        .tick   (tick),
        .cpu_en (cpu_en),
        .halted (halted),
        .state  (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hit();
        return bp_en && m_arm && (pc == bp_pc) && m_tick;
    endfunction

    function automatic bit m_en();
        return m_tick && (m_st == 1 || m_st == 2) && !m_hit();
    endfunction

    function automatic int burst_len();
        return (burst_n == 0) ? 1 : int'(burst_n);
    endfunction

    task automatic model_reset();
        e = 0;
        m_tick = 0;
        m_st = 0;
        m_rem = 0;
        m_arm = 1;
        m_lvl = 0;
        last_chg = 0;
        last_rise = -100;
        last_en = 0;
        runq.delete();
        stepq.delete();
        runq.push_back(1'b0);
        runq.push_back(1'b0);
        stepq.push_back(1'b0);
        stepq.push_back(1'b0);
    endtask

    // Edge e sees the raw input from edge e-2; a step level is accepted
    // after DB_CNT seen samples all differing from the held level, and
    // the FSM reacts to an accepted rise two edges later.
    task automatic model_edge();
        bit hit;
        bit en;
        bit run_s;
        bit sev;
        bit all_new;
        hit = m_hit();
        en = m_en();
        e++;
        runq.push_back(run);
        stepq.push_back(step);
        run_s = runq[e-1];
        sev = (last_rise == e - 2);
        case (m_st)
            0: begin
                if (run_s) m_st = 1;
                else if (sev) begin m_st = 2; m_rem = burst_len(); end
            end
            1: begin
                if (!run_s) m_st = 0;
                else if (hit) begin m_st = 3; m_arm = 0; end
            end
            2: begin
                if (hit) begin
                    m_st = 3;
                    m_arm = 0;
                end else if (en) begin
                    m_rem--;
                    if (m_rem == 0) m_st = 0;
                end
            end
            default: begin
                if (sev) begin m_st = 2; m_rem = burst_len(); end
                else if (!run_s) m_st = 0;
            end
        endcase
        if (en) m_arm = 1;
        if (e - DB_CNT >= last_chg) begin
            all_new = 1;
            for (int j = e - DB_CNT + 1; j <= e; j++)
                if (stepq[j-1] == m_lvl) all_new = 0;
            if (all_new) begin
                m_lvl = !m_lvl;
                last_chg = e;
                if (m_lvl) last_rise = e;
            end
        end
        m_tick = (e % DIV) == 0;
        last_en = en;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        if (last_en) pc = pc + 32'd4;
        #1;
        if (cpu_en) dut_en_cnt++;
        chk("tick", 32'(tick), 32'(m_tick));
        chk("state", 32'(state), 32'(m_st));
        chk("halted", 32'(halted), 32'(m_st == 3));
        chk("cpu_en", 32'(cpu_en), 32'(m_en()));
    endtask

    task automatic press(input int nb);
        for (int k = 0; k < nb; k++) begin
            step = 1'b1;
            repeat ($urandom_range(DB_CNT - 1, 1)) cycle();
            step = 1'b0;
            repeat ($urandom_range(DB_CNT - 1, 1)) cycle();
        end
        step = 1'b1;
        repeat (DB_CNT + 6) cycle();
        for (int k = 0; k < nb; k++) begin
            step = 1'b0;
            repeat ($urandom_range(DB_CNT - 1, 1)) cycle();
            step = 1'b1;
            repeat ($urandom_range(DB_CNT - 1, 1)) cycle();
        end
        step = 1'b0;
        repeat (DB_CNT + 6) cycle();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (state != 2'd0 && n < 300) begin
            cycle();
            n++;
        end
        chk(tag, 32'(state), 32'd0);
    endtask

    task automatic wait_halt(input string tag);
        int n;
        n = 0;
        while (!halted && n < 300) begin
            cycle();
            n++;
        end
        chk(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        int n0;
        int n;
        logic [PC_W-1:0] tgt;
        rst = 1'b1;
        run = 1'b0;
        step = 1'b0;
        burst_n = '0;
        bp_en = 1'b0;
        bp_pc = '0;
        pc = '0;
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;

        n0 = dut_en_cnt;
        repeat (13) cycle();
        chk("div_no_en", 32'(dut_en_cnt - n0), 32'd0);

        run = 1'b1;
        repeat (3) cycle();
        chk("run_state", 32'(state), 32'd1);
        repeat (30) cycle();
        run = 1'b0;
        repeat (3) cycle();
        chk("run_off", 32'(state), 32'd0);
        n0 = dut_en_cnt;
        repeat (20) cycle();
        chk("run_off_quiet", 32'(dut_en_cnt - n0), 32'd0);

        burst_n = 8'd3;
        n0 = dut_en_cnt;
        press(3);
        wait_idle("burst3_idle");
        chk("burst3_en", 32'(dut_en_cnt - n0), 32'd3);
        burst_n = 8'd0;
        n0 = dut_en_cnt;
        press(3);
        wait_idle("burst0_idle");
        chk("burst0_en", 32'(dut_en_cnt - n0), 32'd1);
        burst_n = 8'($urandom_range(7, 2));
        n0 = dut_en_cnt;
        press(2);
        wait_idle("burstN_idle");
        chk("burstN_en", 32'(dut_en_cnt - n0), 32'(burst_n));

        rst = 1'b1;
        cycle();
        pc = '0;
        rst = 1'b0;
        bp_en = 1'b1;
        bp_pc = 32'h0C;
        run = 1'b1;
        wait_halt("bp_halt");
        chk("bp_stop_pc", pc, 32'h0C);
        repeat (20) cycle();
        chk("bp_hold_run", 32'(halted), 32'd1);
        run = 1'b0;
        repeat (3) cycle();
        chk("bp_run_off", 32'(state), 32'd0);
        run = 1'b1;
        repeat (12) cycle();
        chk("bp_rerun", 32'(state), 32'd1);
        chk("bp_past", 32'(pc > 32'h0C), 32'd1);

        tgt = pc + 32'd8;
        bp_pc = tgt;
        wait_halt("bp2_halt");
        chk("bp2_stop_pc", pc, tgt);
        run = 1'b0;
        burst_n = 8'd1;
        press(1);
        wait_idle("bp2_idle");
        chk("bp2_step_pc", pc, tgt + 32'd4);

        bp_en = 1'b0;
        burst_n = 8'd5;
        n0 = dut_en_cnt;
        step = 1'b1;
        n = 0;
        while (dut_en_cnt - n0 < 3 && n < 300) begin
            cycle();
            n++;
        end
        chk("mid_burst_en", 32'(dut_en_cnt - n0), 32'd3);
        #2;
        rst = 1'b1;
        step = 1'b0;
        #1;
        model_reset();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        repeat (2) cycle();
        rst = 1'b0;
        n0 = dut_en_cnt;
        repeat (40) cycle();
        chk("rst_quiet", 32'(dut_en_cnt - n0), 32'd0);

        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(3, 0))
                0: begin
                    run = ~run;
                    repeat ($urandom_range(40, 5)) cycle();
                end
                1: begin
                    burst_n = 8'($urandom_range(4, 0));
                    press(int'($urandom_range(3, 0)));
                end
                2: begin
                    bp_en = 1'($urandom_range(1, 0));
                    bp_pc = pc + 32'(4 * $urandom_range(6, 0));
                    repeat (8) cycle();
                end
                default: repeat ($urandom_range(20, 1)) cycle();
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Parametrised CPU clock-enable and execution-control unit. It sits between the board clock and the pipelined CPU, replacing the fixed divide-by-4 slow clock and the simple run/step selection. It generates a divided tick and gates it into a single-cycle CPU enable according to run, single-step and burst-step modes. It adds a PC breakpoint that halts the CPU before the matching instruction executes.

## Interface
Parameters:
- `DIV`, default 4: tick period in `clk` cycles; must be ≥1.
- `DB_CNT`, default 16: number of consecutive stable `clk` samples needed to accept a new step-button level.
- `PC_W`, default 32: PC width.
- `BURST_W`, default 8: width of the burst count.

Ports:
- `clk`, in, 1: system clock. One clock domain only.
- `rst`, in, 1: reset, asynchronous, active-high.
- `run`, in, 1: run switch, asynchronous level.
- `step`, in, 1: raw step button, asynchronous, bouncing.
- `burst_n`, in, BURST_W: CPU cycles per step press; value 0 is treated as 1.
- `bp_en`, in, 1: breakpoint enable.
- `bp_pc`, in, PC_W: breakpoint address.
- `pc`, in, PC_W: current IF-stage PC from the CPU.
- `tick`, out, 1: divided pulse, high for one `clk` every `DIV` cycles.
- `cpu_en`, out, 1: CPU clock enable, one `clk` wide.
- `halted`, out, 1: high in BREAK state.
- `state`, out, 2: current state encoding.

## Operation
- **Divider**
  - `div_cnt` counts 0..DIV-1 and wraps.
  - `tick` is a registered output, high in the cycle after `div_cnt==DIV-1`.
  - With DIV=1, `tick` stays high continuously after reset.
- **Input conditioning**
  - `run` and `step` each pass through a 2-FF synchroniser.
  - Synchronised `step` feeds the debouncer. `step_pulse` is one `clk` wide, generated on a rising edge of the debounced level.
- **Breakpoint match**
  - `bp_hit = bp_en && armed && pc==bp_pc && tick`.
  - `armed` is cleared on entry to BREAK. It is set again on the first `cpu_en` after leaving BREAK, so the stopped instruction can be stepped past.
- **FSM states:** IDLE=0, RUN=1, STEP=2, BREAK=3.
  - **IDLE**
    - Synchronised `run`=1 → RUN. `run` has priority over `step_pulse`.
    - `step_pulse` → STEP, loading `remain = (burst_n==0) ? 1 : burst_n`.
  - **RUN**
    - `run`=0 → IDLE.
    - `bp_hit` → BREAK.
    - `step_pulse` is ignored.
  - **STEP**
    - Each `cpu_en` decrements `remain`.
    - `cpu_en` while `remain==1` → IDLE.
    - `bp_hit` → BREAK, and the burst is abandoned.
    - `run` and `step_pulse` are ignored.
  - **BREAK**
    - `step_pulse` → STEP, loading `remain` as in IDLE. It takes priority over `run`.
    - Synchronised `run`=0 → IDLE.
    - `run`=1 with no step → stay in BREAK. Resuming run requires toggling `run` off and on.
- **Outputs**
  - `cpu_en = tick && (state==RUN || state==STEP) && !bp_hit`. The breakpointed instruction never receives an enable.
  - `halted = (state==BREAK)`.
- **Reset mid-operation:** immediate return to reset values. Any in-progress burst and the debounce count are discarded.

## Timing
- **Reset values:** `tick`=0, `cpu_en`=0, `halted`=0, `state`=IDLE, `div_cnt`=0, `remain`=0, `armed`=1, debounced level=0, synchronisers=0.
- **First tick:** on the DIV-th rising edge after reset release.
- **run latency:** a `run` change is seen at the state register on the 3rd `clk` edge (2 synchroniser edges + 1 FSM edge). `cpu_en` starts at the first `tick` after that.
- **step latency:** a step press is accepted after 2 + DB_CNT stable cycles. `step_pulse` follows one cycle later, then the state changes at the next edge.
- **Step and tick in the same cycle:** a `step_pulse` coinciding with `tick` in IDLE does not enable the CPU. Execution starts at the next tick.
- **Burst length:** a burst of N produces exactly N `cpu_en` pulses, spaced DIV cycles apart.
- **bp_pc changes:** a change takes effect on the next `tick` compare. No latching.

## Structure
- **Shared header/package `cpu_ctrl_pkg`:** state encodings IDLE, RUN, STEP, BREAK and the state width constant, reused by the PDU display logic.
- **Sub-module `btn_debounce`**, parameter DB_CNT: synchroniser, stable counter and rising-edge pulse. The top instantiates it for `step`.

## Test plan
- **Divider:** DIV=4, reset released at t0 → `tick` on cycles 4, 8, 12. `cpu_en`=0 throughout with `run`=0.
- **Run:** DIV=4, `run`=1 → state=RUN by the 3rd edge and `cpu_en` equals `tick`. `run`=0 → IDLE after 3 edges and no further `cpu_en`.
- **Burst step with bounce:** DB_CNT=4, `burst_n`=3, step pressed with 3 bounces shorter than 4 cycles → exactly one `step_pulse` and exactly 3 `cpu_en` pulses 4 cycles apart, then IDLE. Repeat with `burst_n`=0 → 1 pulse.
- **Breakpoint:** `bp_en`=1, `bp_pc`=0x0C, `run`=1, `pc` advancing 0,4,8,C → `cpu_en` suppressed on the tick where `pc`=0x0C, `halted`=1. One step press → one `cpu_en`, `pc` moves past 0x0C, state returns to IDLE.
- **Async reset:** `rst` asserted mid-burst with `remain`=2 → `cpu_en`, `tick`, `halted` go 0 immediately and state=IDLE. After release, no `cpu_en` occurs without a new step or run.
- **Run in BREAK:** `run` held 1 while in BREAK → stays halted. Toggling `run` 0 then 1 → IDLE then RUN.
